// File: rtl/tl_mon_pkg.sv
// Shared opcode constants, error codes and beat arithmetic
// for the TileLink channel monitor.
package tl_mon_pkg;

    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_ARITH       = 3'd2;
    localparam logic [2:0] A_LOGIC       = 3'd3;
    localparam logic [2:0] A_GET         = 3'd4;

    localparam logic [2:0] D_ACK      = 3'd0;
    localparam logic [2:0] D_ACK_DATA = 3'd1;

    typedef enum logic [3:0] {
        ERR_NONE       = 4'd0,
        ERR_A_OPCODE   = 4'd1,
        ERR_A_SIZE     = 4'd2,
        ERR_A_UNSTABLE = 4'd3,
        ERR_A_BURST    = 4'd4,
        ERR_SRC_REUSE  = 4'd5,
        ERR_D_UNEXP    = 4'd6,
        ERR_D_OPCODE   = 4'd7,
        ERR_D_SIZE     = 4'd8,
        ERR_TIMEOUT    = 4'd9
    } err_e;

    function automatic int beats_of(input int size, input int beat_log2,
                                    input logic multi);
        if (multi && size > beat_log2) return 1 << (size - beat_log2);
        return 1;
    endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Beat position tracker for one TileLink channel; flags the
// first and last beat of the message currently presented.
module tl_beat_counter
    import tl_mon_pkg::*;
#(
    parameter int SIZE_BITS = 3,
    parameter int BEAT_LOG2 = 2,
    parameter bit IS_D      = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 fire_i,
    input  logic [2:0]           opcode_i,
    input  logic [SIZE_BITS-1:0] size_i,
    output logic                 first_o,
    output logic                 last_o
);
    localparam int CW = 1 << SIZE_BITS;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          multi;
    logic [31:0]   last_idx;

    always_comb begin
        if (IS_D) multi = (opcode_i == D_ACK_DATA);
        else      multi = opcode_i inside {A_PUT_FULL, A_PUT_PARTIAL,
                                           A_ARITH, A_LOGIC};
        last_idx = 32'(beats_of(32'(size_i), BEAT_LOG2, multi) - 1);
        first_o  = (cnt_q == '0);
        last_o   = (cnt_q == last_idx[CW-1:0]);
        cnt_d    = cnt_q;
        if (fire_i) cnt_d = last_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tl_channel_monitor.sv
// TileLink-UL/UH A/D channel protocol checker. Purely observational;
// latches the first violation seen into a sticky error record.
module tl_channel_monitor
    import tl_mon_pkg::*;
#(
    parameter int SOURCE_BITS   = 4,
    parameter int SIZE_BITS     = 3,
    parameter int BEAT_LOG2     = 2,
    parameter int MAX_SIZE_LOG2 = 6,
    parameter int ATOMICS       = 0,
    parameter int TIMEOUT       = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    output logic                   err_valid,
    output logic [3:0]             err_code,
    output logic [SOURCE_BITS-1:0] err_source,
    output logic [SOURCE_BITS:0]   inflight_count
);
    localparam int N   = 1 << SOURCE_BITS;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [31:0]    MAX_SZ  = 32'(MAX_SIZE_LOG2);

    logic a_fire, d_fire, a_first, a_last, d_first, d_last;

    logic                   a_stall_q;
    logic [2:0]             a_opc_q, b_opc_q;
    logic [SIZE_BITS-1:0]   a_size_q, b_size_q;
    logic [SOURCE_BITS-1:0] a_src_q, b_src_q;

    logic [N-1:0]                vld_q, vld_d, exp_q, exp_d;
    logic [N-1:0][SIZE_BITS-1:0] sz_q, sz_d;
    logic [SOURCE_BITS:0]        cnt_q, cnt_d;

    logic [WDW-1:0]         wd_q, wd_d;
    logic                   wd_run, tmo;
    logic [SOURCE_BITS-1:0] low_src;

    logic v_opc, v_size, v_unst, v_burst, v_reuse;
    logic v_unexp, v_dopc, v_dsize;

    logic                   viol;
    err_e                   code;
    logic [SOURCE_BITS-1:0] src;
    logic                   err_valid_q, err_valid_d;
    err_e                   err_code_q, err_code_d;
    logic [SOURCE_BITS-1:0] err_src_q, err_src_d;

    assign a_fire = a_valid & a_ready;
    assign d_fire = d_valid & d_ready;

    tl_beat_counter #(
        .SIZE_BITS(SIZE_BITS), .BEAT_LOG2(BEAT_LOG2), .IS_D(1'b0)
    ) u_a_beats (
        .clock(clock), .reset_n(reset_n), .fire_i(a_fire),
        .opcode_i(a_opcode), .size_i(a_size),
        .first_o(a_first), .last_o(a_last)
    );

    tl_beat_counter #(
        .SIZE_BITS(SIZE_BITS), .BEAT_LOG2(BEAT_LOG2), .IS_D(1'b1)
    ) u_d_beats (
        .clock(clock), .reset_n(reset_n), .fire_i(d_fire),
        .opcode_i(d_opcode), .size_i(d_size),
        .first_o(d_first), .last_o(d_last)
    );

    always_comb begin
        v_opc   = a_valid & ((a_opcode > A_GET) |
                  ((ATOMICS == 0) & (a_opcode inside {A_ARITH, A_LOGIC})));
        v_size  = a_valid & (32'(a_size) > MAX_SZ);
        v_unst  = a_stall_q & (~a_valid | (a_opcode != a_opc_q) |
                  (a_size != a_size_q) | (a_source != a_src_q));
        v_burst = a_valid & ~a_first & ((a_opcode != b_opc_q) |
                  (a_size != b_size_q) | (a_source != b_src_q));
        v_reuse = a_fire & a_first & vld_q[a_source];
        v_unexp = d_fire & d_first & ~vld_q[d_source];
        v_dopc  = d_fire & vld_q[d_source] &
                  (d_opcode != (exp_q[d_source] ? D_ACK_DATA : D_ACK));
        v_dsize = d_fire & vld_q[d_source] & (d_size != sz_q[d_source]);
    end

    always_comb begin
        low_src = '0;
        for (int i = N - 1; i >= 0; i--)
            if (vld_q[i]) low_src = SOURCE_BITS'(i);
        wd_run = (cnt_q != '0) & ~d_fire;
        tmo    = (TIMEOUT > 0) & wd_run & (wd_q == WD_LAST);
        wd_d   = '0;
        if (TIMEOUT > 0 && wd_run)
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WDW'(1);
    end

    // Release is applied before set so a same-source pair stays in flight.
    always_comb begin
        vld_d = vld_q;
        exp_d = exp_q;
        sz_d  = sz_q;
        if (d_fire & d_last) vld_d[d_source] = 1'b0;
        if (a_fire & a_last) begin
            vld_d[a_source] = 1'b1;
            exp_d[a_source] = a_opcode inside {A_GET, A_ARITH, A_LOGIC};
            sz_d[a_source]  = a_size;
        end
        cnt_d = '0;
        for (int i = 0; i < N; i++)
            cnt_d = cnt_d + (SOURCE_BITS+1)'(vld_d[i]);
    end

    always_comb begin
        viol = 1'b1;
        code = ERR_NONE;
        src  = '0;
        if (v_opc)        begin code = ERR_A_OPCODE;   src = a_source; end
        else if (v_size)  begin code = ERR_A_SIZE;     src = a_source; end
        else if (v_unst)  begin code = ERR_A_UNSTABLE; src = a_source; end
        else if (v_burst) begin code = ERR_A_BURST;    src = a_source; end
        else if (v_reuse) begin code = ERR_SRC_REUSE;  src = a_source; end
        else if (v_unexp) begin code = ERR_D_UNEXP;    src = d_source; end
        else if (v_dopc)  begin code = ERR_D_OPCODE;   src = d_source; end
        else if (v_dsize) begin code = ERR_D_SIZE;     src = d_source; end
        else if (tmo)     begin code = ERR_TIMEOUT;    src = low_src;  end
        else              viol = 1'b0;

        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        err_src_d   = err_src_q;
        if (viol && (!err_valid_q || clear)) begin
            err_valid_d = 1'b1;
            err_code_d  = code;
            err_src_d   = src;
        end else if (clear) begin
            err_valid_d = 1'b0;
            err_code_d  = ERR_NONE;
            err_src_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_stall_q   <= 1'b0;
            a_opc_q     <= '0;
            a_size_q    <= '0;
            a_src_q     <= '0;
            b_opc_q     <= '0;
            b_size_q    <= '0;
            b_src_q     <= '0;
            vld_q       <= '0;
            exp_q       <= '0;
            sz_q        <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_src_q   <= '0;
        end else begin
            a_stall_q <= a_valid & ~a_ready;
            a_opc_q   <= a_opcode;
            a_size_q  <= a_size;
            a_src_q   <= a_source;
            if (a_fire & a_first) begin
                b_opc_q  <= a_opcode;
                b_size_q <= a_size;
                b_src_q  <= a_source;
            end
            vld_q       <= vld_d;
            exp_q       <= exp_d;
            sz_q        <= sz_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_src_q   <= err_src_d;
        end
    end

    assign err_valid      = err_valid_q;
    assign err_code       = err_code_q;
    assign err_source     = err_src_q;
    assign inflight_count = cnt_q;

endmodule

// File: doc/tl_channel_monitor.md
Name: tl_channel_monitor

Overview:
- Parametrised TileLink-UL/UH A/D channel protocol checker; successor to the fixed per-port assertion monitors.
- Purely observational, placed beside any TL port; never drives the bus.
- Beyond per-beat legality, it tracks in-flight sources, multibeat bursts, request/response pairing and a response watchdog.
- Reports the first violation through a sticky error code instead of stopping the simulation.

Parameters:
SOURCE_BITS, 4, width of a_source/d_source; in-flight table depth is 2**SOURCE_BITS
SIZE_BITS, 3, width of a_size/d_size
BEAT_LOG2, 2, log2 of beat bytes (2 gives a 32-bit data bus)
MAX_SIZE_LOG2, 6, largest legal transfer size (log2 bytes)
ATOMICS, 0, 1 makes ArithmeticData(2) and LogicalData(3) legal on A
TIMEOUT, 1024, watchdog limit in cycles; 0 disables the watchdog

Ports:
clock  in  1  sampling clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of the sticky error state
a_valid  in  1  A valid
a_ready  in  1  A ready
a_opcode  in  3  A opcode
a_size  in  SIZE_BITS  A size (log2 bytes)
a_source  in  SOURCE_BITS  A source id
d_valid  in  1  D valid
d_ready  in  1  D ready
d_opcode  in  3  D opcode
d_size  in  SIZE_BITS  D size
d_source  in  SOURCE_BITS  D source id
err_valid  out  1  sticky; a violation has been seen
err_code  out  4  code of the first violation
err_source  out  SOURCE_BITS  source id involved in that violation
inflight_count  out  SOURCE_BITS+1  number of outstanding requests

Behaviour:
- Reset: all outputs 0; in-flight table, beat counters, hold register and watchdog cleared. Reset mid-burst discards all state with no error.
- Fire definitions: a_fire = a_valid & a_ready; d_fire = d_valid & d_ready.
- Beats for opcode 0/1/2/3 on A, and for opcode 1 on D: 2**(size-BEAT_LOG2) when size > BEAT_LOG2, else 1. All other opcodes have 1 beat.
- First beat: counter == 0. Last beat: counter == beats-1. The counter wraps to 0 after the last beat.
- Latency: a violation is detected on the cycle it is presented; err_* are registered and visible on the next cycle.
- Capture rule: err_* capture only while err_valid = 0. Later violations are ignored until clear.
- clear: err_* become 0 on the next cycle. If clear and a new violation coincide, the violation wins.
- Error codes, priority 1 (highest) to 9:
  1 ILLEGAL_A_OPCODE: opcode 5..7, or 2/3 when ATOMICS = 0.
  2 A_SIZE: a_size > MAX_SIZE_LOG2.
  3 A_UNSTABLE: a_valid & ~a_ready last cycle, and this cycle a_valid drops or opcode/size/source changes.
  4 A_BURST_MISMATCH: on a non-first beat, opcode/size/source differ from the first beat.
  5 SOURCE_REUSE: first A beat fires while the source bit is set in the registered table. A D release of the same source in the same cycle does not excuse it; one idle cycle is required.
  6 D_UNEXPECTED: first D beat fires for a source not in flight.
  7 D_OPCODE: d_opcode is not the expected one (1 AccessAckData for A opcode 4/2/3, 0 AccessAck for 0/1).
  8 D_SIZE: d_size differs from the stored request size.
  9 TIMEOUT: watchdog reaches TIMEOUT.
- In-flight table, per source: valid, expect_data, size.
  - Set on the last A beat fire.
  - Cleared on the last D beat fire.
  - Set and clear in the same cycle (different sources) both apply. Same source: the clear applies, then the set.
- inflight_count: popcount of the valid bits, registered.
- Watchdog:
  - Increments while inflight_count != 0 and no d_fire.
  - Resets to 0 on any d_fire or when inflight_count == 0.
  - Saturates at TIMEOUT and flags once; err_source = lowest in-flight source.
- Checks on invalid fields apply only while the corresponding valid is high.

Decomposition:
- Package tl_mon_pkg: A/D opcode localparams, err_code enum, beats_of() function.
- Sub-module tl_beat_counter (size, opcode, fire → first, last), instanced once per channel.

Test Plan:
- Get src 3 size 2 fires; AccessAckData src 3 size 2 five cycles later → inflight_count 1 then 0, err_valid stays 0.
- PutFull size 4 (BEAT_LOG2 = 2, 4 beats) with a_source changed on beat 3 → err_code 4, err_source = new source, next cycle.
- Get src 5 fires twice with no D between → err_code 5, err_source 5. Assert clear → err_valid 0 the following cycle.
- Get src 1 outstanding, no D for 1024 cycles → err_code 9, err_source 1 exactly at watchdog saturation.
- a_valid held, a_ready low, a_size changes 2 → 3 → err_code 3. Same cycle with opcode 7 → err_code 1 (priority).
- Reset_n asserted mid 4-beat Put, then a fresh Get src 0 and its D → no error, inflight_count returns to 0.
